rs_enc_lfsr: RTL and testbench

RS_ENC_LFSR -- requirements
Module: rs_enc_lfsr

---
 rtl/rs_enc_lfsr.sv | 169 ++++++++++++++++
 tb/tb_rs_enc_lfsr.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_enc_lfsr.sv
// Systematic Reed-Solomon encoder: an LFSR divides m(x)*x^PAR_LEN by g(x), then shifts out the parity.
// Optional build macro RS_ENC_SHORTENED_EN: s_tlast ends a message early (shortened code).

package gf_pkg;

  // Primitive polynomial for GF(2^m), including the x^m term.
  function automatic logic [16:0] prim_poly(input int m);
    case (m)
      3:       prim_poly = 17'h0000B;
      4:       prim_poly = 17'h00013;
      5:       prim_poly = 17'h00025;
      6:       prim_poly = 17'h00043;
      7:       prim_poly = 17'h00089;
      9:       prim_poly = 17'h00211;
      10:      prim_poly = 17'h00409;
      11:      prim_poly = 17'h00805;
      12:      prim_poly = 17'h01053;
      13:      prim_poly = 17'h0201B;
      14:      prim_poly = 17'h04443;
      15:      prim_poly = 17'h08003;
      16:      prim_poly = 17'h1100B;
      default: prim_poly = 17'h0011D;
    endcase
  endfunction

  // Shift-and-add multiply, reducing after every shift; operands are m bits zero-extended to 16.
  function automatic logic [15:0] gf_mult(input logic [15:0] a, input logic [15:0] b, input int m);
    logic [16:0] poly;
    logic [16:0] r;
    poly = prim_poly(m);
    r    = '0;
    for (int i = m - 1; i >= 0; i--) begin
      r = r << 1;
      if (((r >> m) & 17'd1) != 17'd0) r = r ^ poly;
      if (((b >> i) & 16'd1) != 16'd0) r = r ^ {1'b0, a};
    end
    return r[15:0];
  endfunction

endpackage

module rs_enc_lfsr #(
  parameter int SYMB_WIDTH = 8,
  parameter int K_LEN      = 239,
  parameter int PAR_LEN    = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [SYMB_WIDTH-1:0] m_tdata,
  output logic                  err_o
);

  import gf_pkg::*;

  localparam int MCW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int PCW = (PAR_LEN > 1) ? $clog2(PAR_LEN) : 1;

  typedef logic [SYMB_WIDTH-1:0]               symb_t;
  typedef logic [PAR_LEN-1:0][SYMB_WIDTH-1:0]  par_t;
  typedef enum logic {MSG, PAR} state_t;

  function automatic symb_t mul(input symb_t a, input symb_t b);
    return SYMB_WIDTH'(gf_mult(16'(a), 16'(b), SYMB_WIDTH));
  endfunction

  // Expand prod (x + alpha^i) one root at a time; the monic top term is implicit.
  function automatic par_t gen_poly();
    logic [PAR_LEN:0][SYMB_WIDTH-1:0] c;
    symb_t root;
    c    = '0;
    c[0] = symb_t'(1);
    root = symb_t'(1);
    for (int i = 0; i < PAR_LEN; i++) begin
      for (int j = PAR_LEN; j > 0; j--) c[j] = c[j-1] ^ mul(root, c[j]);
      c[0] = mul(root, c[0]);
      root = mul(root, symb_t'(2));
    end
    return c[PAR_LEN-1:0];
  endfunction

  localparam par_t G = gen_poly();

  state_t         state, state_next;
  logic [MCW-1:0] msg_cnt;
  logic [PCW-1:0] par_cnt;
  par_t           p, p_fb, p_shift;
  symb_t          fb;
  logic           slot_free, accept, par_load, msg_last, par_last;
  logic           frame_end, frame_err;

  assign slot_free = !m_tvalid || m_tready;
  assign s_tready  = (state == MSG) && slot_free;
  assign accept    = s_tvalid && s_tready;
  assign par_load  = (state == PAR) && slot_free;
  assign msg_last  = (msg_cnt == MCW'(K_LEN - 1));
  assign par_last  = (par_cnt == PCW'(PAR_LEN - 1));

`ifdef RS_ENC_SHORTENED_EN
  assign frame_end = s_tlast || msg_last;
  assign frame_err = msg_last && !s_tlast;
`else
  assign frame_end = msg_last;
  assign frame_err = (s_tlast != msg_last);
`endif

  assign fb      = s_tdata ^ p[PAR_LEN-1];
  assign p_shift = p << SYMB_WIDTH;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    p_fb    = '0;
    p_fb[0] = mul(fb, G[0]);
    for (int j = 1; j < PAR_LEN; j++) p_fb[j] = p[j-1] ^ mul(fb, G[j]);
  end

  always_comb begin
    state_next = state;
    case (state)
      MSG:     if (accept && frame_end) state_next = PAR;
      PAR:     if (par_load && par_last) state_next = MSG;
      default: state_next = MSG;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= MSG;
    else        state <= state_next;
  end

  // NOTE: the parity registers are plain flops, not a RAM, so they clear with the rest of the state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      msg_cnt  <= '0;
      par_cnt  <= '0;
      p        <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      err_o <= accept && frame_err;
      if (accept) begin
        p        <= p_fb;
        msg_cnt  <= frame_end ? '0 : msg_cnt + MCW'(1);
        m_tdata  <= s_tdata;
        m_tvalid <= 1'b1;
        m_tlast  <= 1'b0;
      end else if (par_load) begin
        m_tdata  <= p[PAR_LEN-1];
        m_tvalid <= 1'b1;
        m_tlast  <= par_last;
        p        <= par_last ? '0 : p_shift;
        par_cnt  <= par_last ? '0 : par_cnt + PCW'(1);
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Self-checking bench for rs_enc_lfsr against a long-division RS(255,239) model over GF(2^8), poly 0x11D.
// Honours RS_ENC_SHORTENED_EN the same way the design does.

module tb_rs_enc_lfsr;

  localparam int SW = 8;
  localparam int K  = 239;
  localparam int P  = 16;
  localparam int N  = K + P;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_tvalid, s_tready, s_tlast;
  logic [SW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [SW-1:0] m_tdata;
  logic          err_o;

  rs_enc_lfsr #(.SYMB_WIDTH(SW), .K_LEN(K), .PAR_LEN(P)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .err_o    (err_o)
  );

  initial forever #5 aclk = ~aclk;

  int    errors = 0;
  int    checks = 0;
  int    err_pulses = 0;
  int    tlast_seen = 0;
  bit    par_window = 1'b0;
  bit    rand_ready = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t out_q[$];
  beat_t exp_q[$];
  int    exp_tab[256];
  int    log_tab[256];
  int    gen[P+1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_tab[(log_tab[a] + log_tab[b]) % 255];
  endfunction

  // Codeword = message followed by remainder of m(x)*x^P / g(x), found by schoolbook long division.
  task automatic make_expected(input int msg[$]);
    int    n;
    int    w[];
    beat_t b;
    n = msg.size();
    w = new[n + P];
    foreach (w[i]) w[i] = (i < n) ? msg[i] : 0;
    for (int i = 0; i < n; i++)
      if (w[i] != 0)
        for (int j = 1; j <= P; j++) w[i+j] ^= gmul(w[i], gen[P-j]);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      b.data = SW'(msg[i]); b.last = 1'b0; exp_q.push_back(b);
    end
    for (int i = 0; i < P; i++) begin
      b.data = SW'(w[n+i]); b.last = (i == P - 1); exp_q.push_back(b);
    end
  endtask

  // Output monitor: collects transfers, counts err_o pulses, checks stall stability and the parity-phase s_tready.
  initial forever begin
    @(negedge aclk);
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_beat.data);
        check("hold_last", m_tlast, prev_beat.last);
      end
      if (par_window) begin
        if (m_tvalid && m_tlast) par_window = 1'b0;
        else check("s_tready_in_par", s_tready, 0);
      end
      if (m_tvalid && m_tready) begin
        prev_beat.data = m_tdata;
        prev_beat.last = m_tlast;
        out_q.push_back(prev_beat);
        if (m_tlast) tlast_seen++;
      end
      if (err_o) err_pulses++;
      prev_stall     = m_tvalid && !m_tready;
      prev_beat.data = m_tdata;
      prev_beat.last = m_tlast;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Enter and leave at a falling edge; idle cycles carry garbage data to show it is ignored.
  task automatic send_symbol(input int d, input bit last, input bit gaps, input bit ends_frame);
    int n;
    if (gaps)
      while ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0; s_tdata = SW'($urandom); s_tlast = 1'($urandom);
        @(negedge aclk);
      end
    s_tvalid = 1'b1; s_tdata = SW'(d); s_tlast = last;
    n = 0;
    while (!s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_tready) check("accept_timeout", s_tready, 1);
    @(posedge aclk);
    if (ends_frame) par_window = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0; s_tdata = SW'($urandom); s_tlast = 1'b0;
  endtask

  task automatic send_msg(input int msg[$], input int tl_a, input int tl_b, input int end_idx, input bit gaps);
    for (int i = 0; i < msg.size(); i++)
      send_symbol(msg[i], (i == tl_a) || (i == tl_b), gaps, i == end_idx);
  endtask

  task automatic compare_frame(input string tag);
    int n;
    n = 0;
    while (out_q.size() < exp_q.size() && n < 4000) begin
      @(negedge aclk);
      n++;
    end
    repeat (20) @(negedge aclk);
    check({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), out_q[i].data, exp_q[i].data);
      check($sformatf("%s_last%0d", tag, i), out_q[i].last, exp_q[i].last);
    end
    out_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int msg[$];
    int e0, t0, x;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_tab[i] = x; log_tab[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    foreach (gen[i]) gen[i] = 0;
    gen[0] = 1;
    for (int i = 0; i < P; i++) begin
      int nxt[P+1];
      foreach (nxt[j]) nxt[j] = gmul(exp_tab[i], gen[j]) ^ ((j > 0) ? gen[j-1] : 0);
      gen = nxt;
    end

    // Reset state
    areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    repeat (3) @(negedge aclk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_err_o", err_o, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_s_tready", s_tready, 1);

    // All-zero message, sink always ready
    msg.delete();
    for (int i = 0; i < K; i++) msg.push_back(0);
    e0 = err_pulses; t0 = tlast_seen;
    make_expected(msg);
    send_msg(msg, K - 1, K - 1, K - 1, 1'b0);
    compare_frame("zero");
    check("zero_tlast_count", tlast_seen - t0, 1);
    check("zero_err", err_pulses - e0, 0);

    // Single 0x01 in the lowest-degree slot: parity is g(x) without its leading term
    msg[K-1] = 1;
    make_expected(msg);
    send_msg(msg, K - 1, K - 1, K - 1, 1'b0);
    for (int i = 0; i < P; i++) begin
      if (K + i < out_q.size())
        check($sformatf("gen_coef%0d", P - 1 - i), out_q[K+i].data, gen[P-1-i]);
    end
    compare_frame("unit");

    // Random messages with source gaps and a 50% sink
    rand_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      msg.delete();
      for (int i = 0; i < K; i++) msg.push_back(int'($urandom_range(0, 255)));
      e0 = err_pulses;
      make_expected(msg);
      send_msg(msg, K - 1, K - 1, K - 1, 1'b1);
      compare_frame($sformatf("rand%0d", f));
      check($sformatf("rand%0d_err", f), err_pulses - e0, 0);
    end

    // Reset after 100 message symbols, then a clean frame
    msg.delete();
    for (int i = 0; i < 100; i++) msg.push_back(int'($urandom_range(0, 255)));
    t0 = tlast_seen;
    send_msg(msg, -1, -1, -1, 1'b1);
    areset = 1'b1;
    #1;
    check("midrst_async_valid", m_tvalid, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("midrst_no_tlast", tlast_seen - t0, 0);
    check("midrst_s_tready", s_tready, 1);
    out_q.delete();
    msg.delete();
    for (int i = 0; i < K; i++) msg.push_back(int'($urandom_range(0, 255)));
    e0 = err_pulses;
    make_expected(msg);
    send_msg(msg, K - 1, K - 1, K - 1, 1'b1);
    compare_frame("postrst");
    check("postrst_err", err_pulses - e0, 0);

    // s_tlast on the 10th symbol
    msg.delete();
    e0 = err_pulses;
`ifdef RS_ENC_SHORTENED_EN
    for (int i = 0; i < 10; i++) msg.push_back(int'($urandom_range(0, 255)));
    make_expected(msg);
    send_msg(msg, 9, 9, 9, 1'b1);
    compare_frame("short");
    check("short_err", err_pulses - e0, 0);
`else
    for (int i = 0; i < K; i++) msg.push_back(int'($urandom_range(0, 255)));
    make_expected(msg);
    send_msg(msg, 9, K - 1, K - 1, 1'b1);
    compare_frame("early_tlast");
    check("early_tlast_err", err_pulses - e0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
